// File: rtl/lagd_ic_reg_demux.sv
// Register-bus demux from the Cheshire reg-slave port to the per-Ising-core register files.
// Optional slave wait timeout enabled by defining LAGD_IC_REG_TIMEOUT_EN.
module lagd_ic_reg_demux #(
  parameter int unsigned          NumCores      = 4,
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          DataWidth     = 32,
  parameter logic [AddrWidth-1:0] BaseAddr      = AddrWidth'(32'h4000_0000),
  parameter int unsigned          CoreStride    = 256,
  parameter int unsigned          TimeoutCycles = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          mst_valid_i,
  input  logic [AddrWidth-1:0]          mst_addr_i,
  input  logic                          mst_write_i,
  input  logic [DataWidth-1:0]          mst_wdata_i,
  input  logic [DataWidth/8-1:0]        mst_wstrb_i,
  output logic                          mst_ready_o,
  output logic [DataWidth-1:0]          mst_rdata_o,
  output logic                          mst_error_o,
  output logic [NumCores-1:0]           slv_valid_o,
  output logic [AddrWidth-1:0]          slv_addr_o,
  output logic                          slv_write_o,
  output logic [DataWidth-1:0]          slv_wdata_o,
  output logic [DataWidth/8-1:0]        slv_wstrb_o,
  input  logic [NumCores-1:0]           slv_ready_i,
  input  logic [NumCores*DataWidth-1:0] slv_rdata_i,
  input  logic [NumCores-1:0]           slv_error_i,
  output logic                          busy_o,
  output logic [7:0]                    err_cnt_o,
  output logic                          timeout_o
);

  localparam int unsigned IdxWidth = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam int unsigned OffShift = $clog2(CoreStride);

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_e;

  // Elaboration-time parameter sanity checks
  if (NumCores < 1 || NumCores > 16 || CoreStride < DataWidth / 8 ||
      (CoreStride & (CoreStride - 1)) != 0 || TimeoutCycles < 1 || TimeoutCycles > 255)
  begin : g_bad_params
    $error("lagd_ic_reg_demux: illegal parameter combination");
  end

  state_e                 state_q, state_d;
  logic [IdxWidth-1:0]    idx_q;
  logic [AddrWidth-1:0]   off, core_sel, fwd_addr;
  logic                   hit, sel_ready, timeout_hit, err_inc;
  logic [DataWidth-1:0]   sel_rdata;
  logic [NumCores-1:0]    slv_valid_d;
  logic                   mst_ready_d, mst_error_d, timeout_d;
  logic [DataWidth-1:0]   mst_rdata_d;

  // Address decode of the incoming request
  assign off       = mst_addr_i - BaseAddr;
  assign core_sel  = off >> OffShift;
  assign hit       = (mst_addr_i >= BaseAddr) && (core_sel < AddrWidth'(NumCores));
  assign fwd_addr  = off & AddrWidth'(CoreStride - 1);

  assign sel_ready = slv_ready_i[idx_q];
  assign sel_rdata = slv_rdata_i[32'(idx_q) * DataWidth +: DataWidth];

`ifdef LAGD_IC_REG_TIMEOUT_EN
  logic [7:0] wait_q;

  // Limit is reached on the FWD cycle that would bring the counter to TimeoutCycles
  assign timeout_hit = (state_q == FWD) && !sel_ready && (wait_q == 8'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= 8'd0;
    end else if (state_q != FWD) begin
      wait_q <= 8'd0;
    end else if (!sel_ready) begin
      wait_q <= wait_q + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mst_valid_i) state_d = hit ? FWD : RESP;
      FWD:     if (sel_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    slv_valid_d = '0;
    mst_ready_d = 1'b0;
    mst_error_d = 1'b0;
    mst_rdata_d = '0;
    timeout_d   = 1'b0;
    err_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mst_valid_i && hit) begin
          slv_valid_d = NumCores'(1) << core_sel[IdxWidth-1:0];
        end else if (mst_valid_i) begin
          mst_ready_d = 1'b1;
          mst_error_d = 1'b1;
          err_inc     = 1'b1;
        end
      end
      FWD: begin
        if (sel_ready) begin
          mst_ready_d = 1'b1;
          mst_error_d = slv_error_i[idx_q];
          mst_rdata_d = slv_write_o ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          mst_ready_d = 1'b1;
          mst_error_d = 1'b1;
          timeout_d   = 1'b1;
          err_inc     = 1'b1;
        end else begin
          slv_valid_d = slv_valid_o;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      slv_addr_o  <= '0;
      slv_write_o <= 1'b0;
      slv_wdata_o <= '0;
      slv_wstrb_o <= '0;
      slv_valid_o <= '0;
      mst_ready_o <= 1'b0;
      mst_error_o <= 1'b0;
      mst_rdata_o <= '0;
      timeout_o   <= 1'b0;
      busy_o      <= 1'b0;
      err_cnt_o   <= 8'd0;
    end else begin
      if (state_q == IDLE && mst_valid_i) begin
        idx_q       <= core_sel[IdxWidth-1:0];
        slv_addr_o  <= fwd_addr;
        slv_write_o <= mst_write_i;
        slv_wdata_o <= mst_wdata_i;
        slv_wstrb_o <= mst_wstrb_i;
      end
      slv_valid_o <= slv_valid_d;
      mst_ready_o <= mst_ready_d;
      mst_error_o <= mst_error_d;
      mst_rdata_o <= mst_rdata_d;
      timeout_o   <= timeout_d;
      busy_o      <= (state_d != IDLE);
      if (err_inc && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_lagd_ic_reg_demux.sv
// Directed bench for lagd_ic_reg_demux: decode, latency, misses, timeout/no-timeout, reset, saturation.
module tb_lagd_ic_reg_demux;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              mst_valid_i;
  logic [AW-1:0]     mst_addr_i;
  logic              mst_write_i;
  logic [DW-1:0]     mst_wdata_i;
  logic [DW/8-1:0]   mst_wstrb_i;
  logic              mst_ready_o;
  logic [DW-1:0]     mst_rdata_o;
  logic              mst_error_o;
  logic [NC-1:0]     slv_valid_o;
  logic [AW-1:0]     slv_addr_o;
  logic              slv_write_o;
  logic [DW-1:0]     slv_wdata_o;
  logic [DW/8-1:0]   slv_wstrb_o;
  logic [NC-1:0]     slv_ready_i;
  logic [NC*DW-1:0]  slv_rdata_i;
  logic [NC-1:0]     slv_error_i;
  logic              busy_o;
  logic [7:0]        err_cnt_o;
  logic              timeout_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_err;
  logic       seen_bad;

  always #5 clk_i = ~clk_i;

  lagd_ic_reg_demux #(
    .NumCores(NC), .AddrWidth(AW), .DataWidth(DW), .BaseAddr(32'h4000_0000),
    .CoreStride(256), .TimeoutCycles(255)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mst_valid_i(mst_valid_i), .mst_addr_i(mst_addr_i), .mst_write_i(mst_write_i),
    .mst_wdata_i(mst_wdata_i), .mst_wstrb_i(mst_wstrb_i),
    .mst_ready_o(mst_ready_o), .mst_rdata_o(mst_rdata_o), .mst_error_o(mst_error_o),
    .slv_valid_o(slv_valid_o), .slv_addr_o(slv_addr_o), .slv_write_o(slv_write_o),
    .slv_wdata_o(slv_wdata_o), .slv_wstrb_o(slv_wstrb_o),
    .slv_ready_i(slv_ready_i), .slv_rdata_i(slv_rdata_i), .slv_error_i(slv_error_i),
    .busy_o(busy_o), .err_cnt_o(err_cnt_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    mst_valid_i = 1'b1;
    mst_addr_i  = a;
    mst_write_i = w;
    mst_wdata_i = d;
    mst_wstrb_i = s;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni      = 1'b0;
    mst_valid_i = 1'b0;
    mst_addr_i  = '0;
    mst_write_i = 1'b0;
    mst_wdata_i = '0;
    mst_wstrb_i = '0;
    slv_ready_i = '0;
    slv_error_i = '0;
    slv_rdata_i = {32'hD00D_0003, 32'hC0DE_0002, 32'h5555_AAAA, 32'h1234_5678};
    exp_err     = 8'd0;

    // Reset state
    tick(); tick();
    chk("rst_ready", mst_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", slv_valid_o, 0);
    chk("rst_errcnt", err_cnt_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_rdata", mst_rdata_o, 0);
    chk("rst_error", mst_error_o, 0);
    chk("rst_addr", slv_addr_o, 0);
    #4 rst_ni = 1'b1;
    tick();

    // 1: write to core 2, ready immediately
    req(32'h4000_0208, 1'b1, 32'hCAFE_F00D, 4'hF);
    slv_ready_i = 4'b0100;
    tick();
    chk("t1_valid", slv_valid_o, 4'b0100);
    chk("t1_addr", slv_addr_o, 32'h8);
    chk("t1_wdata", slv_wdata_o, 32'hCAFE_F00D);
    chk("t1_wstrb", slv_wstrb_o, 4'hF);
    chk("t1_write", slv_write_o, 1);
    chk("t1_ready_early", mst_ready_o, 0);
    tick();
    chk("t1_ready", mst_ready_o, 1);
    chk("t1_error", mst_error_o, 0);
    chk("t1_rdata_wr", mst_rdata_o, 0);
    chk("t1_busy_resp", busy_o, 1);
    mst_valid_i = 1'b0;
    slv_ready_i = '0;
    tick();
    chk("t1_ready_pulse", mst_ready_o, 0);
    chk("t1_idle_busy", busy_o, 0);

    // 2: read core 0, ready after 3 FWD cycles; other cores' ready/error ignored
    req(32'h4000_0010, 1'b0, 32'h0, 4'hF);
    slv_ready_i = 4'b1110;
    slv_error_i = 4'b1110;
    tick();
    chk("t2_valid", slv_valid_o, 4'b0001);
    chk("t2_addr", slv_addr_o, 32'h10);
    chk("t2_busy1", busy_o, 1);
    tick();
    chk("t2_ready_c2", mst_ready_o, 0);
    chk("t2_busy2", busy_o, 1);
    tick();
    slv_ready_i = 4'b0001;
    chk("t2_ready_c3", mst_ready_o, 0);
    tick();
    chk("t2_ready", mst_ready_o, 1);
    chk("t2_rdata", mst_rdata_o, 32'h1234_5678);
    chk("t2_error", mst_error_o, 0);
    chk("t2_busy_resp", busy_o, 1);
    mst_valid_i = 1'b0;
    slv_ready_i = '0;
    slv_error_i = '0;
    tick();
    chk("t2_rdata_idle", mst_rdata_o, 0);

    // 3: two misses (above the last core, below base)
    req(32'h4000_0400, 1'b0, 32'h0, 4'hF);
    tick();
    exp_err = exp_err + 8'd1;
    chk("t3a_ready", mst_ready_o, 1);
    chk("t3a_error", mst_error_o, 1);
    chk("t3a_rdata", mst_rdata_o, 0);
    chk("t3a_valid", slv_valid_o, 0);
    chk("t3a_errcnt", err_cnt_o, exp_err);
    mst_valid_i = 1'b0;
    tick();
    req(32'h3FFF_FFFC, 1'b0, 32'h0, 4'hF);
    tick();
    exp_err = exp_err + 8'd1;
    chk("t3b_ready", mst_ready_o, 1);
    chk("t3b_error", mst_error_o, 1);
    chk("t3b_valid", slv_valid_o, 0);
    chk("t3b_errcnt", err_cnt_o, 8'd2);
    mst_valid_i = 1'b0;
    tick();

`ifdef LAGD_IC_REG_TIMEOUT_EN
    // 4a: core 1 never ready -> timeout after 255 FWD cycles
    req(32'h4000_0100, 1'b0, 32'h0, 4'hF);
    tick();
    seen_bad = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      seen_bad = seen_bad | timeout_o | mst_ready_o | (slv_valid_o != 4'b0010);
      tick();
    end
    chk("t4a_wait_clean", seen_bad, 0);
    chk("t4a_valid_c255", slv_valid_o, 4'b0010);
    tick();
    exp_err = exp_err + 8'd1;
    chk("t4a_timeout", timeout_o, 1);
    chk("t4a_ready", mst_ready_o, 1);
    chk("t4a_error", mst_error_o, 1);
    chk("t4a_rdata", mst_rdata_o, 0);
    chk("t4a_valid_drop", slv_valid_o, 0);
    chk("t4a_errcnt", err_cnt_o, exp_err);
    mst_valid_i = 1'b0;
    tick();
    chk("t4a_timeout_pulse", timeout_o, 0);

    // 4b: ready arrives exactly on FWD cycle 255 -> normal response
    req(32'h4000_0100, 1'b0, 32'h0, 4'hF);
    tick();
    seen_bad = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      seen_bad = seen_bad | timeout_o | mst_ready_o;
      tick();
    end
    slv_ready_i = 4'b0010;
    tick();
    chk("t4b_wait_clean", seen_bad, 0);
    chk("t4b_timeout", timeout_o, 0);
    chk("t4b_ready", mst_ready_o, 1);
    chk("t4b_error", mst_error_o, 0);
    chk("t4b_rdata", mst_rdata_o, 32'h5555_AAAA);
    chk("t4b_errcnt", err_cnt_o, exp_err);
    mst_valid_i = 1'b0;
    slv_ready_i = '0;
    tick();
`else
    // 4: no timeout -> FWD waits well beyond 255 cycles
    req(32'h4000_0100, 1'b0, 32'h0, 4'hF);
    tick();
    seen_bad = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      seen_bad = seen_bad | timeout_o | mst_ready_o | !busy_o | (slv_valid_o != 4'b0010);
      tick();
    end
    chk("t4_wait_clean", seen_bad, 0);
    slv_ready_i = 4'b0010;
    tick();
    chk("t4_timeout", timeout_o, 0);
    chk("t4_ready", mst_ready_o, 1);
    chk("t4_rdata", mst_rdata_o, 32'h5555_AAAA);
    chk("t4_errcnt", err_cnt_o, exp_err);
    mst_valid_i = 1'b0;
    slv_ready_i = '0;
    tick();
`endif

    // 5: reset during FWD, then a normal access and a back-to-back access
    req(32'h4000_0304, 1'b0, 32'h0, 4'hF);
    tick();
    chk("t5_valid_pre", slv_valid_o, 4'b1000);
    #1 rst_ni = 1'b0;
    mst_valid_i = 1'b0;
    #1;
    chk("t5_rst_valid", slv_valid_o, 0);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_addr", slv_addr_o, 0);
    chk("t5_rst_errcnt", err_cnt_o, 0);
    chk("t5_rst_ready", mst_ready_o, 0);
    exp_err = 8'd0;
    #2 rst_ni = 1'b1;
    tick();
    chk("t5_no_resp", mst_ready_o, 0);
    req(32'h4000_0104, 1'b1, 32'h0000_BEEF, 4'h3);
    slv_ready_i = 4'b0010;
    tick();
    chk("t5_valid", slv_valid_o, 4'b0010);
    chk("t5_wstrb", slv_wstrb_o, 4'h3);
    chk("t5_wdata", slv_wdata_o, 32'h0000_BEEF);
    tick();
    chk("t5_ready", mst_ready_o, 1);
    chk("t5_rdata_wr", mst_rdata_o, 0);
    req(32'h4000_020C, 1'b0, 32'h0, 4'hF);
    slv_ready_i = 4'b0100;
    slv_error_i = 4'b0100;
    tick();
    chk("t5_b2b_idle_ready", mst_ready_o, 0);
    chk("t5_b2b_idle_busy", busy_o, 0);
    tick();
    chk("t5_b2b_valid", slv_valid_o, 4'b0100);
    chk("t5_b2b_addr", slv_addr_o, 32'hC);
    tick();
    chk("t5_b2b_ready", mst_ready_o, 1);
    chk("t5_b2b_rdata", mst_rdata_o, 32'hC0DE_0002);
    chk("t5_b2b_slverr", mst_error_o, 1);
    chk("t5_b2b_errcnt", err_cnt_o, 0);
    mst_valid_i = 1'b0;
    slv_ready_i = '0;
    slv_error_i = '0;
    tick();

    // 6: 300 misses saturate the error counter
    seen_bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      req(32'h5000_0000, 1'b0, 32'h0, 4'hF);
      tick();
      seen_bad = seen_bad | !mst_ready_o | !mst_error_o;
      if (i == 254) chk("t6_errcnt_255", err_cnt_o, 8'hFF);
      mst_valid_i = 1'b0;
      tick();
    end
    chk("t6_miss_resp", seen_bad, 0);
    chk("t6_errcnt_sat", err_cnt_o, 8'hFF);
    req(32'h4000_0300, 1'b0, 32'h0, 4'hF);
    slv_ready_i = 4'b1000;
    tick();
    chk("t6_hit_valid", slv_valid_o, 4'b1000);
    tick();
    chk("t6_hit_ready", mst_ready_o, 1);
    chk("t6_hit_rdata", mst_rdata_o, 32'hD00D_0003);
    chk("t6_hit_error", mst_error_o, 0);
    chk("t6_hit_errcnt", err_cnt_o, 8'hFF);
    mst_valid_i = 1'b0;
    slv_ready_i = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
